rr_arbiter_16: RTL and testbench

Sixteen-way round-robin arbiter that shares a single decoded resource among 16 requesters. It selects one requester at a time and presents the winner both as a 4-bit index and as a one-hot 16-bit grant vector, using the same 4-to-16 one-hot encoding as the team's decoders. It sits between the requester bank and the shared datapath, and holds each grant until the owner releases it, the block is disabled, or (optionally) a hold limit expires.

---
 rtl/rr_arbiter_16.sv | 88 ++++++++
 tb/tb_rr_arbiter_16.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with registered one-hot/index grant.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD hold-limit counter and timeout pulse.
module rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d, idx_q, idx_d, win, cand;
  logic [15:0] gnt_q, gnt_d;
  logic        valid_q, valid_d, tmo_q, tmo_d, found, expire;
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = valid_q ? cnt_q + 8'd1 : 8'd0;
  assign expire = (cnt_q + 8'd1) == 8'(MAX_HOLD);
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
`else
  assign expire = 1'b0;
`endif
  // first set request at or above ptr, wrapping 15 -> 0
  always_comb begin
    win = 4'd0;
    found = 1'b0;
    cand = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = ptr_q + 4'(k);
      if (!found && req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    gnt_d = gnt_q;
    valid_d = valid_q;
    tmo_d = 1'b0;
    if (state_q == IDLE) begin
      if (enable && found) begin
        state_d = GRANT;
        idx_d = win;
        gnt_d = 16'd1 << win;
        valid_d = 1'b1;
        ptr_d = win + 4'd1;
      end
    end else if (!enable || !req[idx_q] || expire) begin
      state_d = IDLE;
      idx_d = 4'd0;
      gnt_d = 16'd0;
      valid_d = 1'b0;
      tmo_d = expire && enable && req[idx_q];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 4'd0;
      idx_q <= 4'd0;
      gnt_q <= 16'd0;
      valid_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      gnt_q <= gnt_d;
      valid_q <= valid_d;
      tmo_q <= tmo_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_valid = valid_q;
  assign timeout = tmo_q;
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: table vectors, hand sequences and a random run against a reference model.
module tb_rr_arbiter_16;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [15:0] req = 16'h0;
  logic [15:0] gnt;
  logic [3:0] gnt_idx;
  logic gnt_valid, timeout;
  int total = 0, bad = 0;
  int m_valid = 0, m_idx = 0, m_ptr = 0, m_cycles = 0, m_tmo = 0;
  always #5 clk = ~clk;
  rr_arbiter_16 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  typedef struct {
    logic        r;
    logic        en;
    logic [15:0] rq;
    logic        v;
    logic [3:0]  idx;
  } vec_t;
  vec_t tv[14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // abstract model: owner number, rotating priority start, cycles held
  task automatic model_update();
    bit hit;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_cycles = 0; m_tmo = 0;
    end else if (m_valid != 0) begin
      hit = TMO && (m_cycles >= MH);
      m_tmo = 0;
      if (!enable || !req[m_idx] || hit) begin
        m_tmo = (enable && req[m_idx] && hit) ? 1 : 0;
        m_valid = 0; m_idx = 0;
      end else m_cycles++;
    end else begin
      m_tmo = 0;
      if (enable && req != 16'h0) begin
        for (int k = 0; k < 16; k++)
          if (m_valid == 0 && req[(m_ptr + k) % 16]) begin
            m_idx = (m_ptr + k) % 16;
            m_valid = 1;
          end
        m_ptr = (m_idx + 1) % 16;
        m_cycles = 1;
      end
    end
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic check_model(input string tag);
    check({tag, ".gnt"}, 32'(gnt), (m_valid != 0) ? (32'd1 << m_idx) : 32'd0);
    check({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(m_valid));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_tmo));
  endtask
  task automatic check_const(input string tag, input bit v, input int idx, input bit t);
    check({tag, ".gnt"}, 32'(gnt), v ? (32'd1 << idx) : 32'd0);
    check({tag, ".idx"}, 32'(gnt_idx), v ? 32'(idx) : 32'd0);
    check({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd0};
    tv[1]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'd0};
    tv[2]  = '{1'b0, 1'b1, 16'h8001, 1'b1, 4'd0};
    tv[3]  = '{1'b0, 1'b1, 16'h8001, 1'b1, 4'd0};
    tv[4]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 4'd0};
    tv[5]  = '{1'b0, 1'b1, 16'h8000, 1'b1, 4'd15};
    tv[6]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'd0};
    tv[7]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 4'd0};
    tv[8]  = '{1'b0, 1'b0, 16'h0001, 1'b0, 4'd0};
    tv[9]  = '{1'b0, 1'b0, 16'h0021, 1'b0, 4'd0};
    tv[10] = '{1'b0, 1'b1, 16'h0021, 1'b1, 4'd5};
    tv[11] = '{1'b0, 1'b1, 16'h0021, 1'b1, 4'd5};
    tv[12] = '{1'b1, 1'b1, 16'h0021, 1'b0, 4'd0};
    tv[13] = '{1'b0, 1'b1, 16'h0021, 1'b1, 4'd0};
    // reset then idle with no requests
    rst = 1'b1; enable = 1'b1; req = 16'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_const("idle", 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < 14; i++) begin
      rst = tv[i].r; enable = tv[i].en; req = tv[i].rq;
      tick();
      check_const($sformatf("vec%0d", i), tv[i].v, int'(tv[i].idx), 1'b0);
    end
    // all requesting: each owner holds 3 cycles then drops, order 0..15,0
    rst = 1'b1; req = 16'h0; enable = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 17; r++) begin
      req = 16'hFFFF;
      tick();
      check_const($sformatf("rr%0d.g", r), 1'b1, r % 16, 1'b0);
      tick();
      check_const($sformatf("rr%0d.h1", r), 1'b1, r % 16, 1'b0);
      tick();
      check_const($sformatf("rr%0d.h2", r), 1'b1, r % 16, 1'b0);
      req = 16'hFFFF & ~(16'd1 << (r % 16));
      tick();
      check_const($sformatf("rr%0d.rel", r), 1'b0, 0, 1'b0);
    end
    // enable dropped while idx 5 owns; next grant goes to 6
    rst = 1'b1; req = 16'h0; enable = 1'b1;
    tick();
    rst = 1'b0; req = 16'h0020;
    tick();
    check_const("en.g5", 1'b1, 5, 1'b0);
    enable = 1'b0; req = 16'h0061;
    tick();
    check_const("en.off1", 1'b0, 0, 1'b0);
    tick();
    check_const("en.off2", 1'b0, 0, 1'b0);
    enable = 1'b1;
    tick();
    check_const("en.g6", 1'b1, 6, 1'b0);
`ifdef ARB_TIMEOUT_EN
    // hold limit of 4 cycles with two persistent requesters
    rst = 1'b1; req = 16'h0;
    tick();
    rst = 1'b0; req = 16'h0003;
    tick();
    check_const("to.g0", 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_const("to.h0", 1'b1, 0, 1'b0);
    end
    tick();
    check_const("to.pulse", 1'b0, 0, 1'b1);
    tick();
    check_const("to.g1", 1'b1, 1, 1'b0);
`endif
    // random traffic against the model
    rst = 1'b1; req = 16'h0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      enable = ($urandom_range(9) != 0);
      if ($urandom_range(2) == 0) req = req ^ (16'd1 << $urandom_range(15));
      tick();
      check_model("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
